// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared definitions for the sequential Booth multiplier.
//   MULT_WIDTH    default operand width
//   mult_state_e  control FSM encoding (MS_IDLE / MS_RUN)
//   BOOTH_ADD/SUB radix-2 Booth codes formed from {Q[0], q_1}
package mult_seq_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_RUN  = 1'b1
    } mult_state_e;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/mult_seq_booth_step.sv
// booth_step: one combinational radix-2 Booth iteration (add/sub then arithmetic shift).
//   a_i/a_o   WIDTH+1  accumulator in/out
//   q_i/q_o   WIDTH    multiplier/low product in/out
//   q1_i/q1_o 1        Booth guard bit in/out
//   m_i       WIDTH+1  sign-extended multiplicand
module booth_step
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);

    logic [1:0]     code;
    logic [WIDTH:0] sum;

    assign code = {q_i[0], q1_i};

    always_comb begin
        sum = code == BOOTH_ADD ? a_i + m_i :
              code == BOOTH_SUB ? a_i - m_i : a_i;
    end

    // Arithmetic shift of {A,Q,q_1}: replicate A's sign, drop the old q_1.
    assign {a_o, q_o, q1_o} = {sum[WIDTH], sum, q_i};

endmodule

// File: rtl/mult_seq.sv
// mult_seq: sequential signed radix-2 Booth multiplier, one iteration per clock.
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   Multsrca   multiplicand, sampled on the start edge
//   Multsrcb   multiplier, sampled on the start edge
//   doMult     start request, honoured only when idle
//   MultHI     product upper WIDTH bits, registered
//   MultLO     product lower WIDTH bits, registered
//   busy       iteration in progress
//   mult_done  one-cycle pulse, product valid from this cycle on
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] Multsrca,
    input  logic [WIDTH-1:0] Multsrcb,
    input  logic             doMult,
    output logic [WIDTH-1:0] MultHI,
    output logic [WIDTH-1:0] MultLO,
    output logic             busy,
    output logic             mult_done
);

    localparam int CW = $clog2(WIDTH);

    mult_state_e      state_q, state_d;
    logic [CW-1:0]    count_q;
    logic [WIDTH:0]   m_q, a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d, hi_q, lo_q;
    logic             q1_q, q1_d, done_q;
    logic             start, last;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a_i  (a_q),
        .q_i  (q_q),
        .q1_i (q1_q),
        .m_i  (m_q),
        .a_o  (a_d),
        .q_o  (q_d),
        .q1_o (q1_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= MS_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = start ? MS_RUN : last ? MS_IDLE : state_q;
    end

    always_comb begin
        busy  = state_q == MS_RUN;
        start = state_q == MS_IDLE && doMult;
        last  = busy && count_q == CW'(WIDTH - 1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last;
            if (start) begin
                count_q <= '0;
                m_q     <= {Multsrca[WIDTH-1], Multsrca};
                a_q     <= '0;
                q_q     <= Multsrcb;
                q1_q    <= 1'b0;
            end else if (busy) begin
                count_q <= count_q + 1'b1;
                a_q     <= a_d;
                q_q     <= q_d;
                q1_q    <= q1_d;
                // Only the final iteration reaches the outputs.
                if (last) begin
                    hi_q <= a_d[WIDTH-1:0];
                    lo_q <= q_d;
                end
            end
        end
    end

    assign MultHI    = hi_q;
    assign MultLO    = lo_q;
    assign mult_done = done_q;

endmodule
